alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Controller that shares the single combinational ALU between two requesters. It round-robin arbitrates opcode/operand requests and latches the winner into registers that drive the ALU. It waits a per-opcode cycle count so MUL and DIV get multi-cycle timing, captures the result, and returns it on one response channel tagged with the requester id. Divide-by-zero is trapped here so the ALU divider output is never used for b == 0.

Parameters:
DATA_WIDTH, 16, operand/result width; must match the ALU instance.
MUL_CYCLES, 2, cycles the ALU inputs are held for opcode 3'b010 before capture; >= 1.
DIV_CYCLES, 4, cycles held for opcode 3'b011 before capture; >= 1.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 handshake accepted this cycle
req0_oc  in  3  requester 0 opcode
req0_a  in  DATA_WIDTH  requester 0 operand a
req0_b  in  DATA_WIDTH  requester 0 operand b
req1_valid, req1_ready, req1_oc, req1_a, req1_b  same as requester 0, for requester 1
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_id  out  1  requester that issued the result
rsp_data  out  DATA_WIDTH  captured ALU result
rsp_dz  out  1  divide-by-zero flag for this result
alu_oc  out  3  registered opcode to the ALU
alu_a  out  DATA_WIDTH  registered operand a to the ALU
alu_b  out  DATA_WIDTH  registered operand b to the ALU
alu_f  in  DATA_WIDTH  ALU result
busy  out  1  high whenever state != IDLE

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- On reset: state=IDLE, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_dz=0, alu_oc/alu_a/alu_b=0, cnt=0, last_grant=1 (so requester 0 wins the first contention).
- FSM states: IDLE, EXEC, RESP.
- IDLE, arbitration:
  - reqN_ready is combinational: (state==IDLE) && grant==N.
  - Only one valid: that requester is granted.
  - Both valid: the requester that is not last_grant is granted.
  - Neither valid: both ready signals stay 0.
- IDLE, accept (reqN_valid && reqN_ready at a rising edge):
  - Latch oc/a/b into alu_oc/alu_a/alu_b; latch id; last_grant <= N; go to EXEC.
  - L = MUL_CYCLES for 3'b010, DIV_CYCLES for 3'b011, 1 otherwise; cnt <= L-1.
  - DIV with b==0: L forced to 1, flag dz latched.
- EXEC:
  - alu_* hold stable.
  - cnt != 0: decrement.
  - cnt == 0: rsp_data <= (dz ? 0 : alu_f), rsp_dz <= dz, rsp_valid <= 1, go to RESP.
  - Net timing: rsp_valid rises exactly L edges after the accepting edge.
- RESP:
  - rsp_valid, rsp_id, rsp_data and rsp_dz hold stable until rsp_valid && rsp_ready at an edge.
  - At that edge: rsp_valid <= 0, go to IDLE.
  - No new request is accepted in the same cycle; earliest next accept is the edge after the response handshake.
- Requests arriving during EXEC/RESP see ready=0 and must hold valid and payload. Requester payload changes while ready=0 are ignored.
- Width rules: none applied here; result truncation/wrap (e.g. MUL low DATA_WIDTH bits) comes from the ALU.
- Reset asserted mid-EXEC or mid-RESP: immediate return to the reset values; the in-flight operation is dropped with no response.
- Opcode 3'b100 (NOT) ignores b; b==0 is not flagged for any opcode except 3'b011.

Decomposition:
- Shared package alu_pkg: opcode constants OC_ADD=000, OC_SUB=001, OC_MUL=010, OC_DIV=011, OC_NOT=100, OC_XOR=101, OC_OR=110, OC_AND=111; FSM state encoding.
- Cycle-counter width: $clog2 of max(MUL_CYCLES, DIV_CYCLES)+1.
- One natural sub-module: rr_arbiter2 (two valids, last_grant in, grant out, purely combinational). The ALU stays a separate instance in the parent, wired to alu_oc/alu_a/alu_b/alu_f.

Test Plan:
1. req0 ADD a=5 b=3, rsp_ready=1 -> req0_ready=1 in that cycle; rsp_valid 1 edge after accept; rsp_data=8, rsp_id=0, rsp_dz=0; busy low one cycle later.
2. req0 and req1 both valid from reset (req0 SUB 10-4, req1 XOR 0x00FF^0x0F0F), valids held -> req0 served first (rsp_data=6, id 0), then req1 (rsp_data=0x0FF0, id 1); repeated contention alternates.
3. req1 MUL a=300 b=300 with MUL_CYCLES=2 -> rsp_valid exactly 2 edges after accept; rsp_data=0x5F90 (90000 mod 2^16); alu_a/alu_b stable throughout EXEC.
4. req0 DIV a=100 b=0 -> rsp_valid 1 edge after accept; rsp_data=0, rsp_dz=1. Then DIV 100/7 -> rsp_valid after 4 edges, rsp_data=14, rsp_dz=0.
5. AND 0xF0F0&0xFF00 with rsp_ready=0 for 5 cycles -> rsp_valid/rsp_data=0xF000 held stable; req1 pending sees ready=0; accepted only on the edge after the rsp_ready handshake.
6. rst_n pulled low 2 cycles into a DIV EXEC -> all outputs reset asynchronously, no rsp_valid. After release, a new ADD 1+1 returns rsp_data=2 normally.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: constants shared by the ALU sequencer slice.
//   - ALU opcode encodings (match the shared ALU instance).
//   - FSM state encodings for alu_sequencer.
//   - max2(): constant helper used to size the latency counter.
package alu_pkg;

  localparam logic [2:0] OC_ADD = 3'b000;
  localparam logic [2:0] OC_SUB = 3'b001;
  localparam logic [2:0] OC_MUL = 3'b010;
  localparam logic [2:0] OC_DIV = 3'b011;
  localparam logic [2:0] OC_NOT = 3'b100;
  localparam logic [2:0] OC_XOR = 3'b101;
  localparam logic [2:0] OC_OR  = 3'b110;
  localparam logic [2:0] OC_AND = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  function automatic int max2(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter, purely combinational.
// Ports:
//   valid0/valid1 : requester has an operation pending
//   last_grant    : requester granted most recently (0 or 1)
//   gnt0/gnt1     : one-hot grant, both low when nobody is valid
module rr_arbiter2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic gnt0,
  output logic gnt1
);

  // Under contention the requester that did not win last time is favoured.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (valid0 && valid1) begin
      gnt0 = last_grant;
      gnt1 = ~last_grant;
    end else begin
      gnt0 = valid0;
      gnt1 = valid1;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: shares one combinational ALU between two requesters.
// Arbitrates requests round-robin, registers the winner onto alu_oc/a/b,
// holds them for a per-opcode number of cycles, captures alu_f and returns
// it on a single response channel tagged with the requester id.
// Ports:
//   clk, rst_n                  : clock, async active-low reset
//   reqN_valid/ready/oc/a/b     : requester N request channel (N = 0, 1)
//   rsp_valid/ready/id/data/dz  : response channel, dz = divide-by-zero
//   alu_oc/alu_a/alu_b, alu_f   : registered ALU inputs, ALU result
//   busy                        : high whenever not idle
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [2:0]            req0_oc,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [2:0]            req1_oc,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_dz,
  output logic [2:0]            alu_oc,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_f,
  output logic                  busy
);

  localparam int CNT_W = $clog2(max2(MUL_CYCLES, DIV_CYCLES) + 1);

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  last_grant_q, last_grant_d;
  logic                  id_q, id_d;
  logic                  dz_q, dz_d;
  logic [2:0]            alu_oc_q, alu_oc_d;
  logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_id_q, rsp_id_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_dz_q, rsp_dz_d;

  logic                  gnt0_s, gnt1_s;
  logic                  accept_s;
  logic [2:0]            sel_oc_s;
  logic [DATA_WIDTH-1:0] sel_a_s, sel_b_s;
  logic                  sel_dz_s;
  logic [CNT_W-1:0]      sel_cnt_s;

  rr_arbiter2 u_arb (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant_q),
    .gnt0       (gnt0_s),
    .gnt1       (gnt1_s)
  );

  assign req0_ready = (state_q == ST_IDLE) && gnt0_s;
  assign req1_ready = (state_q == ST_IDLE) && gnt1_s;
  assign accept_s   = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  assign sel_oc_s = gnt1_s ? req1_oc : req0_oc;
  assign sel_a_s  = gnt1_s ? req1_a  : req0_a;
  assign sel_b_s  = gnt1_s ? req1_b  : req0_b;
  // Only DIV traps a zero divisor; the trapped op completes in one cycle.
  assign sel_dz_s = (sel_oc_s == OC_DIV) && (sel_b_s == {DATA_WIDTH{1'b0}});

  // Counter preload is latency minus one: capture happens on the edge where cnt is 0.
  always_comb begin
    sel_cnt_s = {CNT_W{1'b0}};
    case (sel_oc_s)
      OC_MUL:  sel_cnt_s = CNT_W'(MUL_CYCLES - 1);
      OC_DIV:  begin
        if (sel_dz_s) begin
          sel_cnt_s = {CNT_W{1'b0}};
        end else begin
          sel_cnt_s = CNT_W'(DIV_CYCLES - 1);
        end
      end
      default: sel_cnt_s = {CNT_W{1'b0}};
    endcase
  end

  // Next-state logic: accept in IDLE, count down in EXEC, hold response in RESP.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    dz_d         = dz_q;
    alu_oc_d     = alu_oc_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_dz_d     = rsp_dz_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          alu_oc_d     = sel_oc_s;
          alu_a_d      = sel_a_s;
          alu_b_d      = sel_b_s;
          id_d         = gnt1_s;
          last_grant_d = gnt1_s;
          dz_d         = sel_dz_s;
          cnt_d        = sel_cnt_s;
          state_d      = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (cnt_q != {CNT_W{1'b0}}) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // A trapped divide never forwards the divider output.
          rsp_data_d  = dz_q ? {DATA_WIDTH{1'b0}} : alu_f;
          rsp_dz_d    = dz_q;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State registers; last_grant resets to 1 so requester 0 wins first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      dz_q         <= 1'b0;
      alu_oc_q     <= 3'b000;
      alu_a_q      <= {DATA_WIDTH{1'b0}};
      alu_b_q      <= {DATA_WIDTH{1'b0}};
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= {DATA_WIDTH{1'b0}};
      rsp_dz_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      dz_q         <= dz_d;
      alu_oc_q     <= alu_oc_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_dz_q     <= rsp_dz_d;
    end
  end

  assign alu_oc    = alu_oc_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_dz    = rsp_dz_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed self-checking bench for alu_sequencer.
// A small behavioural ALU closes the alu_oc/a/b -> alu_f loop; its divider
// returns 16'hDEAD for b == 0 so a missing trap shows up in rsp_data.
module tb_alu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready;
  logic [2:0]  req0_oc;
  logic [15:0] req0_a, req0_b;
  logic        req1_valid, req1_ready;
  logic [2:0]  req1_oc;
  logic [15:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_dz;
  logic [15:0] rsp_data;
  logic [2:0]  alu_oc;
  logic [15:0] alu_a, alu_b, alu_f;
  logic        busy;
  logic [31:0] prod;

  int n_cmp;
  int n_bad;

  alu_sequencer #(
    .DATA_WIDTH (16),
    .MUL_CYCLES (2),
    .DIV_CYCLES (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_oc    (req0_oc),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_oc    (req1_oc),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_dz     (rsp_dz),
    .alu_oc     (alu_oc),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_f      (alu_f),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU driven by the sequencer's registered outputs.
  always_comb begin
    prod  = {16'h0000, alu_a} * {16'h0000, alu_b};
    alu_f = 16'h0000;
    case (alu_oc)
      3'b000:  alu_f = alu_a + alu_b;
      3'b001:  alu_f = alu_a - alu_b;
      3'b010:  alu_f = prod[15:0];
      3'b011:  alu_f = (alu_b == 16'h0000) ? 16'hDEAD : (alu_a / alu_b);
      3'b100:  alu_f = ~alu_a;
      3'b101:  alu_f = alu_a ^ alu_b;
      3'b110:  alu_f = alu_a | alu_b;
      3'b111:  alu_f = alu_a & alu_b;
      default: alu_f = 16'h0000;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Requester(s) already driven; checks grant, latency, operand hold and response.
  task automatic serve(input logic exp_id, input logic [15:0] exp_a, input logic [15:0] exp_b,
                       input logic [15:0] exp_data, input logic exp_dz, input int exp_lat);
    int lat;
    check_eq("ready_win",  exp_id ? req1_ready : req0_ready, 32'd1);
    check_eq("ready_lose", exp_id ? req0_ready : req1_ready, 32'd0);
    tick();
    check_eq("busy_exec", busy, 32'd1);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      check_eq("alu_a_hold", alu_a, exp_a);
      check_eq("alu_b_hold", alu_b, exp_b);
      tick();
      lat++;
    end
    check_eq("latency",  lat, exp_lat);
    check_eq("rsp_data", rsp_data, exp_data);
    check_eq("rsp_id",   rsp_id, exp_id);
    check_eq("rsp_dz",   rsp_dz, exp_dz);
    tick();
    check_eq("rsp_drop", rsp_valid, 32'd0);
    check_eq("busy_idle", busy, 32'd0);
  endtask

  task automatic run_op(input logic n, input logic [2:0] oc, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp_data,
                        input logic exp_dz, input int exp_lat);
    if (n) begin
      req1_valid = 1'b1; req1_oc = oc; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_oc = oc; req0_a = a; req0_b = b;
    end
    #1;
    serve(n, a, b, exp_data, exp_dz, exp_lat);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_oc = 3'b000; req0_a = 16'h0000; req0_b = 16'h0000;
    req1_valid = 1'b0; req1_oc = 3'b000; req1_a = 16'h0000; req1_b = 16'h0000;
    rsp_ready = 1'b1;

    // Reset values
    repeat (2) tick();
    check_eq("rst_rsp_valid", rsp_valid, 32'd0);
    check_eq("rst_rsp_id",    rsp_id, 32'd0);
    check_eq("rst_rsp_data",  rsp_data, 32'd0);
    check_eq("rst_rsp_dz",    rsp_dz, 32'd0);
    check_eq("rst_alu_oc",    alu_oc, 32'd0);
    check_eq("rst_alu_a",     alu_a, 32'd0);
    check_eq("rst_alu_b",     alu_b, 32'd0);
    check_eq("rst_busy",      busy, 32'd0);
    check_eq("rst_ready0",    req0_ready, 32'd0);
    check_eq("rst_ready1",    req1_ready, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: single ADD
    run_op(1'b0, 3'b000, 16'd5, 16'd3, 16'd8, 1'b0, 1);

    // 2: contention from reset, alternating grants
    do_reset();
    req0_valid = 1'b1; req0_oc = 3'b001; req0_a = 16'd10;    req0_b = 16'd4;
    req1_valid = 1'b1; req1_oc = 3'b101; req1_a = 16'h00FF; req1_b = 16'h0F0F;
    #1;
    serve(1'b0, 16'd10, 16'd4, 16'd6, 1'b0, 1);
    serve(1'b1, 16'h00FF, 16'h0F0F, 16'h0FF0, 1'b0, 1);
    serve(1'b0, 16'd10, 16'd4, 16'd6, 1'b0, 1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // 3: MUL, two-cycle hold, wrap to 16 bits
    run_op(1'b1, 3'b010, 16'd300, 16'd300, 16'h5F90, 1'b0, 2);

    // 4: DIV by zero trapped, then normal DIV
    run_op(1'b0, 3'b011, 16'd100, 16'd0, 16'd0, 1'b1, 1);
    run_op(1'b0, 3'b011, 16'd100, 16'd7, 16'd14, 1'b0, 4);

    // NOT with b == 0 is not flagged
    run_op(1'b1, 3'b100, 16'h1234, 16'd0, 16'hEDCB, 1'b0, 1);

    // 5: response back-pressure with a pending requester
    req0_valid = 1'b1; req0_oc = 3'b111; req0_a = 16'hF0F0; req0_b = 16'hFF00;
    #1;
    check_eq("bp_ready0", req0_ready, 32'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_oc = 3'b000; req1_a = 16'd2; req1_b = 16'd3;
    rsp_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_valid",  rsp_valid, 32'd1);
      check_eq("bp_data",   rsp_data, 32'h0000F000);
      check_eq("bp_ready1", req1_ready, 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check_eq("bp_hs_valid", rsp_valid, 32'd0);
    check_eq("bp_no_accept", alu_a, 32'h0000F0F0);
    check_eq("bp_ready1_now", req1_ready, 32'd1);
    tick();
    check_eq("bp_accept_a", alu_a, 32'd2);
    check_eq("bp_busy", busy, 32'd1);
    req1_valid = 1'b0;
    tick();
    check_eq("bp_r1_valid", rsp_valid, 32'd1);
    check_eq("bp_r1_data",  rsp_data, 32'd5);
    check_eq("bp_r1_id",    rsp_id, 32'd1);
    tick();

    // 6: reset in the middle of a DIV
    req0_valid = 1'b1; req0_oc = 3'b011; req0_a = 16'd100; req0_b = 16'd7;
    #1;
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy",  busy, 32'd0);
    check_eq("mid_rst_alu_a", alu_a, 32'd0);
    check_eq("mid_rst_alu_oc", alu_oc, 32'd0);
    check_eq("mid_rst_valid", rsp_valid, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("mid_rst_hold", rsp_valid, 32'd0);
    end
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_valid", rsp_valid, 32'd0);
    run_op(1'b0, 3'b000, 16'd1, 16'd1, 16'd2, 1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
